wb_queue: RTL

Write-back queue between the execute/memory stages and the processor register file. It accepts register write requests from the ALU path and the load path over valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file's single write port (`rw`/`addr3`/`data3`). It also reports read-after-write hazards so decode stalls while a source register still has a pending write.

---
 rtl/wb_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Write-back queue: arbitrates load/ALU write requests into an in-order FIFO
// and drains one entry per cycle onto the register file write port.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_valid,
  input  logic [AW-1:0]                mem_addr,
  input  logic [DW-1:0]                mem_data,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_addr,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_ready,
  output logic                         rw,
  output logic [AW-1:0]                addr3,
  output logic [DW-1:0]                data3,
  input  logic [AW-1:0]                rd_addr1,
  input  logic [AW-1:0]                rd_addr2,
  output logic                         hazard1,
  output logic                         hazard2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_push_mem;
  logic          w_push_alu;
  logic [AW-1:0] w_push_addr;
  logic [DW-1:0] w_push_data;
  logic          w_enq;
  logic          w_pop;
  logic [PW-1:0] w_off   [DEPTH];
  logic [DEPTH-1:0] w_occ;
  logic [DEPTH-1:0] w_match1;
  logic [DEPTH-1:0] w_match2;

  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  // Readiness depends only on registered occupancy; a same-cycle pop never frees a slot.
  assign mem_ready = rst_n & ~full;
  assign alu_ready = rst_n & ~full & ~mem_valid;

  assign w_push_mem  = mem_valid & mem_ready;
  assign w_push_alu  = alu_valid & alu_ready;
  assign w_push_addr = w_push_mem ? mem_addr : alu_addr;
  assign w_push_data = w_push_mem ? mem_data : alu_data;
  // Writes to register 0 are acknowledged but dropped.
  assign w_enq       = (w_push_mem | w_push_alu) & (w_push_addr != '0);
  assign w_pop       = ~empty;

  assign rw    = ~empty;
  assign addr3 = empty ? '0 : r_addr[r_rd_ptr];
  assign data3 = empty ? '0 : r_data[r_rd_ptr];

  always_comb begin
    w_occ    = '0;
    w_match1 = '0;
    w_match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i]    = PW'(i) - r_rd_ptr;
      w_occ[i]    = ({{(CW-PW){1'b0}}, w_off[i]} < r_count);
      w_match1[i] = (r_addr[i] == rd_addr1);
      w_match2[i] = (r_addr[i] == rd_addr2);
    end
  end

  assign hazard1 = (rd_addr1 != '0) & (|(w_occ & w_match1));
  assign hazard2 = (rd_addr2 != '0) & (|(w_occ & w_match2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && w_enq) begin
      r_addr[r_wr_ptr] <= w_push_addr;
      r_data[r_wr_ptr] <= w_push_data;
    end
  end

endmodule
